// File: rtl/led_activity_mon.sv
// led_activity_mon
//   Turns raw PHY activity into stretched enable levels for the activity and
//   error LED blinkers. It also keeps a link-state FSM and a saturating error
//   tally for debug readout.
//
//   Optional feature macro: LED_ACTIVITY_MON_RX_GLITCH_FILTER_EN
//     When defined, an RX falling edge counts as activity only after synced rx
//     has stayed low for GLITCH_CLKS consecutive samples. It fires once per
//     low period.
//
//   Ports
//     clk        in   system clock, rising edge
//     n_reset    in   synchronous active-low reset
//     rx         in   async serial RX line, idle high
//     tx_start   in   1-cycle strobe at TX frame start
//     err_pulse  in   1-cycle strobe on PHY/framing error
//     err_clear  in   level, ends the error hold (err_pulse has priority)
//     act_enable out  activity LED blinker enable (registered)
//     err_enable out  error LED blinker enable (registered)
//     link_state out  0=IDLE 1=ACTIVE 2=ERROR (registered)
//     err_total  out  saturating count of err_pulse cycles (registered)
module led_activity_mon #(
  parameter int     SYNC_STAGES   = 2,
  parameter longint HOLD_CLKS     = 4096,
  parameter longint ERR_HOLD_CLKS = 65536,
  parameter int     GLITCH_CLKS   = 3
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rx,
  input  logic       tx_start,
  input  logic       err_pulse,
  input  logic       err_clear,
  output logic       act_enable,
  output logic       err_enable,
  output logic [1:0] link_state,
  output logic [7:0] err_total
);

  // Elaboration-time parameter checks
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (HOLD_CLKS < 1 || HOLD_CLKS > 64'sh0000_0000_FFFF_FFFF) begin : g_bad_hold
    $error("HOLD_CLKS must be in 1..2^32-1");
  end
  if (ERR_HOLD_CLKS < 1 || ERR_HOLD_CLKS > 64'sh0000_0000_FFFF_FFFF) begin : g_bad_ehold
    $error("ERR_HOLD_CLKS must be in 1..2^32-1");
  end
  if (GLITCH_CLKS < 1) begin : g_bad_glitch
    $error("GLITCH_CLKS must be >= 1");
  end

  localparam logic [31:0] HOLD_V     = 32'(HOLD_CLKS);
  localparam logic [31:0] ERR_HOLD_V = 32'(ERR_HOLD_CLKS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  // ---------------------------------------------------------------- RX sync
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_sync;
  logic                   rx_event;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rx_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!n_reset) sync_q <= '1;
    else          sync_q <= sync_d;
  end

`ifdef LED_ACTIVITY_MON_RX_GLITCH_FILTER_EN
  // glt_cnt_q counts low samples already seen in the current low period.
  // It saturates at GLITCH_CLKS, so the compare against GLITCH_CLKS-1 is
  // true for exactly one sample per low period.
  localparam int            GW     = $clog2(GLITCH_CLKS + 1);
  localparam logic [GW-1:0] G_FIRE = GW'(GLITCH_CLKS - 1);
  localparam logic [GW-1:0] G_MAX  = GW'(GLITCH_CLKS);

  logic [GW-1:0] glt_cnt_q, glt_cnt_d;

  always_comb begin
    glt_cnt_d = glt_cnt_q;
    rx_event  = 1'b0;
    if (rx_sync) begin
      glt_cnt_d = '0;
    end else begin
      rx_event = (glt_cnt_q == G_FIRE);
      if (glt_cnt_q != G_MAX) glt_cnt_d = glt_cnt_q + GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) glt_cnt_q <= '0;
    else          glt_cnt_q <= glt_cnt_d;
  end
`else
  logic rx_prev_q, rx_prev_d;

  always_comb begin
    rx_prev_d = rx_sync;
    rx_event  = rx_prev_q & ~rx_sync;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) rx_prev_q <= 1'b1;
    else          rx_prev_q <= rx_prev_d;
  end
`endif

  // ---------------------------------------------------------- hold counters
  logic [31:0] act_cnt_q, act_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic [7:0]  err_total_q, err_total_d;
  logic        act_enable_q, act_enable_d;
  logic        err_enable_q, err_enable_d;
  logic        act_event;

  assign act_event = rx_event | tx_start;

  always_comb begin
    act_cnt_d = act_cnt_q;
    if (act_event)             act_cnt_d = HOLD_V;
    else if (act_cnt_q != '0)  act_cnt_d = act_cnt_q - 32'd1;

    err_cnt_d = err_cnt_q;
    if (err_pulse)             err_cnt_d = ERR_HOLD_V;
    else if (err_clear)        err_cnt_d = '0;
    else if (err_cnt_q != '0)  err_cnt_d = err_cnt_q - 32'd1;

    err_total_d = err_total_q;
    if (err_pulse && err_total_q != 8'hFF) err_total_d = err_total_q + 8'd1;

    // Enables track the post-update counters so they move on the same edge
    act_enable_d = (act_cnt_d != '0);
    err_enable_d = (err_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      act_cnt_q    <= '0;
      err_cnt_q    <= '0;
      err_total_q  <= '0;
      act_enable_q <= 1'b0;
      err_enable_q <= 1'b0;
    end else begin
      act_cnt_q    <= act_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_total_q  <= err_total_d;
      act_enable_q <= act_enable_d;
      err_enable_q <= err_enable_d;
    end
  end

  // ------------------------------------------------------- link-state FSM
  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!n_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state depends only on the post-update counters, so every state can
  // reach every other state directly (e.g. ERROR -> ACTIVE).
  always_comb begin
    state_d = ST_IDLE;
    if (err_cnt_d != '0)      state_d = ST_ERROR;
    else if (act_cnt_d != '0) state_d = ST_ACTIVE;
  end

  always_comb begin
    link_state = state_q;
    act_enable = act_enable_q;
    err_enable = err_enable_q;
    err_total  = err_total_q;
  end

endmodule
